// File: rtl/dma_bus_arbiter.sv
// CPU/DMA memory-bus arbiter: hands the bus over only at memory-idle boundaries
// and drives one registered memory port from the current owner.
module dma_bus_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int WORD_SIZE   = 16
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   BR,
  output logic                   BG,
  input  logic                   dma_write,
  input  logic [15:0]            dma_addr,
  input  logic [1:0]             dma_offset,
  input  logic [4*WORD_SIZE-1:0] dma_data,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [15:0]            cpu_addr,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic                   cpu_stall,
  output logic                   cpu_done,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_burst,
  output logic [15:0]            mem_addr,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  output logic                   offset_err
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {CPU_OWN, CPU_ACC, DMA_OWN, DMA_ACC} state_t;

  state_t                   r_state, w_state_next;
  logic [CW-1:0]            r_cnt, w_cnt_next;
  logic                     r_bg, w_bg_next;
  logic                     r_mem_read, w_mem_read_next;
  logic                     r_mem_write, w_mem_write_next;
  logic                     r_mem_burst, w_mem_burst_next;
  logic [15:0]              r_mem_addr, w_mem_addr_next;
  logic [4*WORD_SIZE-1:0]   r_mem_wdata, w_mem_wdata_next;
  logic                     r_offset_err, w_offset_err_next;
  logic                     w_cnt_zero;
  logic                     w_dma_wr;

  assign w_cnt_zero = (r_cnt == '0);
  // A floating WRITE line must never start a burst.
  assign w_dma_wr   = (dma_write === 1'b1);

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_mem_read_next   = r_mem_read;
    w_mem_write_next  = r_mem_write;
    w_mem_burst_next  = r_mem_burst;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_offset_err_next = 1'b0;
    case (r_state)
      CPU_OWN: begin
        if (BR) begin
          w_state_next = DMA_OWN;
        end else if (cpu_read || cpu_write) begin
          w_state_next     = CPU_ACC;
          w_cnt_next       = CNT_LOAD;
          w_mem_write_next = cpu_write;
          w_mem_read_next  = !cpu_write;
          w_mem_burst_next = 1'b0;
          w_mem_addr_next  = cpu_addr;
          w_mem_wdata_next = (4*WORD_SIZE)'(cpu_wdata);
        end
      end
      CPU_ACC: begin
        if (w_cnt_zero) begin
          w_mem_read_next  = 1'b0;
          w_mem_write_next = 1'b0;
          w_state_next     = BR ? DMA_OWN : CPU_OWN;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      DMA_OWN: begin
        if (w_dma_wr) begin
          if (dma_offset != 2'd3) begin
            w_state_next     = DMA_ACC;
            w_cnt_next       = CNT_LOAD;
            w_mem_read_next  = 1'b0;
            w_mem_write_next = 1'b1;
            w_mem_burst_next = 1'b1;
            w_mem_addr_next  = dma_addr + {12'd0, dma_offset, 2'b00};
            w_mem_wdata_next = dma_data;
          end else begin
            w_offset_err_next = 1'b1;
          end
        end else if (!BR) begin
          w_state_next = CPU_OWN;
        end
      end
      DMA_ACC: begin
        if (w_cnt_zero) begin
          w_mem_read_next  = 1'b0;
          w_mem_write_next = 1'b0;
          w_mem_burst_next = 1'b0;
          w_state_next     = BR ? DMA_OWN : CPU_OWN;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: w_state_next = CPU_OWN;
    endcase
    // Grant follows the registered owner, so it can only change where strobes end.
    w_bg_next = (w_state_next == DMA_OWN) || (w_state_next == DMA_ACC);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= CPU_OWN;
      r_cnt        <= '0;
      r_bg         <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_burst  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_offset_err <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bg         <= w_bg_next;
      r_mem_read   <= w_mem_read_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_burst  <= w_mem_burst_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_offset_err <= w_offset_err_next;
    end
  end

  assign BG         = r_bg;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_burst  = r_mem_burst;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign offset_err = r_offset_err;

  // Gated by reset_n so every output reads 0 the moment reset asserts.
  assign cpu_done  = reset_n && (r_state == CPU_ACC) && w_cnt_zero;
  assign cpu_stall = reset_n && (((r_state == CPU_ACC) && !w_cnt_zero) ||
                                 (r_state == DMA_OWN) || (r_state == DMA_ACC) ||
                                 ((r_state == CPU_OWN) && BR && (cpu_read || cpu_write)));

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: CPU accesses, DMA bursts, handover,
// offset rejection and asynchronous reset, checked with immediate assertions.
module tb_dma_bus_arbiter;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        BR;
  logic        BG;
  logic        dma_write;
  logic [15:0] dma_addr;
  logic [1:0]  dma_offset;
  logic [63:0] dma_data;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_done;
  logic        mem_read;
  logic        mem_write;
  logic        mem_burst;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        offset_err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dma_bus_arbiter #(.MEM_LATENCY(4), .WORD_SIZE(16)) dut (
    .CLK(CLK), .reset_n(reset_n), .BR(BR), .BG(BG),
    .dma_write(dma_write), .dma_addr(dma_addr), .dma_offset(dma_offset), .dma_data(dma_data),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .mem_read(mem_read), .mem_write(mem_write),
    .mem_burst(mem_burst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .offset_err(offset_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // CPU access of MEM_LATENCY=4 cycles; optionally raises BR after cycle index br_at.
  task automatic cpu_access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                            input int br_at);
    cpu_write = wr;
    cpu_read  = !wr;
    cpu_addr  = addr;
    cpu_wdata = data;
    tick();
    chk("cpu_addr", mem_addr, addr);
    chk("cpu_burst", mem_burst, 1'b0);
    if (wr) chk("cpu_wdata", mem_wdata, {48'd0, data});
    for (int i = 0; i < 4; i++) begin
      chk(wr ? "cpu_mem_write" : "cpu_mem_read", wr ? mem_write : mem_read, 1'b1);
      chk("cpu_done", cpu_done, (i == 3));
      chk("cpu_stall", cpu_stall, (i != 3));
      chk("cpu_bg_held", BG, 1'b0);
      if (i == br_at) BR = 1'b1;
      if (i == 3) begin
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
      end
      tick();
    end
    $display("cpu %s addr=%h data=%h done", wr ? "write" : "read", addr, data);
  endtask

  // DMA burst from DMA_OWN; optionally drops BR after cycle index drop_at.
  task automatic do_burst(input logic [1:0] off, input logic [15:0] base,
                          input logic [15:0] exp_addr, input logic [63:0] d, input int drop_at);
    dma_addr   = base;
    dma_offset = off;
    dma_data   = d;
    dma_write  = 1'b1;
    tick();
    dma_write = 1'b0;
    chk("dma_wdata", mem_wdata, d);
    for (int i = 0; i < 4; i++) begin
      chk("dma_mem_write", mem_write, 1'b1);
      chk("dma_burst", mem_burst, 1'b1);
      chk("dma_addr", mem_addr, exp_addr);
      chk("dma_bg", BG, 1'b1);
      chk("dma_stall", cpu_stall, 1'b1);
      if (i == drop_at) BR = 1'b0;
      tick();
    end
    chk("dma_strobe_end", mem_write, 1'b0);
    $display("dma burst base=%h off=%0d addr=%h", base, off, exp_addr);
  endtask

  initial begin
    reset_n = 1'b0; BR = 1'b0; dma_write = 1'b0; dma_addr = '0; dma_offset = '0;
    dma_data = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick();
    tick();
    chk("rst_bg", BG, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_stall", cpu_stall, 1'b0);
    reset_n = 1'b1;
    tick();
    $display("reset released");

    // CPU read on an idle bus
    cpu_access(1'b0, 16'h0010, 16'h0000, -1);
    chk("rd_after_strobe", mem_read, 1'b0);
    chk("rd_after_stall", cpu_stall, 1'b0);
    chk("rd_after_done", cpu_done, 1'b0);

    // CPU write, BR arrives during its second cycle: grant waits for completion
    cpu_access(1'b1, 16'h0020, 16'hBEEF, 1);
    chk("hand_mem_write", mem_write, 1'b0);
    chk("hand_bg", BG, 1'b1);
    chk("hand_stall", cpu_stall, 1'b1);

    // Bursts at offsets 0,1,2 from 0x01F4
    do_burst(2'd0, 16'h01F4, 16'h01F4, 64'h1111_2222_3333_4444, -1);
    chk("b0_bg", BG, 1'b1);
    do_burst(2'd1, 16'h01F4, 16'h01F8, 64'h5555_6666_7777_8888, -1);
    chk("b1_bg", BG, 1'b1);
    do_burst(2'd2, 16'h01F4, 16'h01FC, 64'h9999_AAAA_BBBB_CCCC, -1);
    chk("b2_bg", BG, 1'b1);

    // Address wrap plus BR dropping mid-burst with a CPU read pending
    cpu_read = 1'b1;
    cpu_addr = 16'h0040;
    do_burst(2'd2, 16'hFFFC, 16'h0004, 64'hDEAD_BEEF_0123_4567, 1);
    chk("drop_bg", BG, 1'b0);
    chk("drop_stall", cpu_stall, 1'b0);
    chk("drop_mem_read", mem_read, 1'b0);
    cpu_access(1'b0, 16'h0040, 16'h0000, -1);

    // Same-cycle BR and CPU read: DMA wins
    BR = 1'b1;
    cpu_read = 1'b1;
    cpu_addr = 16'h0050;
    #1;
    chk("tie_stall_comb", cpu_stall, 1'b1);
    tick();
    chk("tie_bg", BG, 1'b1);
    chk("tie_mem_read", mem_read, 1'b0);
    chk("tie_stall", cpu_stall, 1'b1);
    $display("tie: DMA granted");

    // Offset 3 burst is rejected
    dma_addr = 16'h0100;
    dma_offset = 2'd3;
    dma_write = 1'b1;
    tick();
    dma_write = 1'b0;
    chk("off3_err", offset_err, 1'b1);
    chk("off3_mem_write", mem_write, 1'b0);
    chk("off3_bg", BG, 1'b1);
    tick();
    chk("off3_err_pulse", offset_err, 1'b0);
    $display("offset 3 burst rejected");
    BR = 1'b0;
    tick();
    chk("release_bg", BG, 1'b0);
    chk("release_stall", cpu_stall, 1'b0);
    cpu_access(1'b0, 16'h0050, 16'h0000, -1);

    // Asynchronous reset in the middle of a burst
    BR = 1'b1;
    tick();
    chk("pre_rst_bg", BG, 1'b1);
    dma_addr = 16'h1234;
    dma_offset = 2'd0;
    dma_data = 64'hFFFF_0000_FFFF_0000;
    dma_write = 1'b1;
    tick();
    dma_write = 1'b0;
    chk("pre_rst_write", mem_write, 1'b1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_bg", BG, 1'b0);
    chk("arst_mem_write", mem_write, 1'b0);
    chk("arst_mem_burst", mem_burst, 1'b0);
    chk("arst_mem_addr", mem_addr, 16'h0000);
    chk("arst_mem_wdata", mem_wdata, 64'h0);
    chk("arst_stall", cpu_stall, 1'b0);
    BR = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_bg", BG, 1'b0);
    chk("post_rst_write", mem_write, 1'b0);
    $display("async reset mid-burst");
    cpu_access(1'b1, 16'h0060, 16'h0A0A, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
